// File: rtl/rectangle128_pkg.sv
// RECTANGLE-128 encryption core: shared constants,
// S-box and FSM state encoding.
package rectangle128_pkg;

    localparam int RECT_NROUNDS = 25;
    localparam int ROW_W        = 16;
    localparam int BLK_W        = 4 * ROW_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        y = '0;
        unique case (x)
            4'h0: y = 4'h6;
            4'h1: y = 4'h5;
            4'h2: y = 4'hC;
            4'h3: y = 4'hA;
            4'h4: y = 4'h1;
            4'h5: y = 4'hE;
            4'h6: y = 4'h7;
            4'h7: y = 4'h9;
            4'h8: y = 4'hB;
            4'h9: y = 4'h0;
            4'hA: y = 4'h3;
            4'hB: y = 4'hD;
            4'hC: y = 4'h8;
            4'hD: y = 4'hF;
            4'hE: y = 4'h4;
            4'hF: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/rectangle128_enc_core_if.sv
// Block handshake bundle: plaintext in, ciphertext out,
// both valid/ready.
interface rectangle128_enc_core_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] plaintext;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ciphertext;

    modport master (
        output in_valid,
        output plaintext,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ciphertext
    );

    modport slave (
        input  in_valid,
        input  plaintext,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ciphertext
    );

endinterface

// File: rtl/rectangle128_keymem.sv
// Subkey store: one write port from the key schedule,
// combinational read port for the round datapath.
import rectangle128_pkg::*;

module rectangle128_keymem #(
    parameter int DEPTH = RECT_NROUNDS + 1
) (
    input  logic        Clk,
    input  logic        RstN,
    input  logic        flush,
    input  logic        WE,
    input  logic [4:0]  WAddr,
    input  logic [63:0] KeyIn,
    input  logic [4:0]  RAddr,
    output logic [63:0] RData,
    output logic        key_ready
);

    logic [63:0] mem [DEPTH];

    logic wr_ok;
    logic set_rdy;
    logic clr_rdy;

    assign wr_ok   = WE && (WAddr <= 5'(DEPTH - 1));
    assign set_rdy = WE && (WAddr == 5'(DEPTH - 1));
    assign clr_rdy = !flush || (WE && (WAddr == 5'd0));

    assign RData = mem[RAddr];

    // Storage is not reset; key_ready alone gates its use.
    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            mem[WAddr] <= KeyIn;
        end
    end

    // Ready once the last subkey lands; any clear wins.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            key_ready <= 1'b0;
        end else if (clr_rdy) begin
            key_ready <= 1'b0;
        end else if (set_rdy) begin
            key_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/rectangle128_enc_core.sv
// RECTANGLE-128 iterative encryption core, one round
// per cycle, subkeys read from rectangle128_keymem.
import rectangle128_pkg::*;

module rectangle128_enc_core #(
    parameter int NROUNDS = RECT_NROUNDS
) (
    input  logic                     Clk,
    input  logic                     RstN,
    input  logic                     flush,
    input  logic                     WE,
    input  logic [4:0]               WAddr,
    input  logic [63:0]              KeyIn,
    rectangle128_enc_core_if.slave   bus,
    output logic                     key_ready,
    output logic                     busy
);

    fsm_t             fsm;
    logic [4:0]       rnd;
    logic [BLK_W-1:0] st;
    logic [BLK_W-1:0] ct;
    logic             ov_q;
    logic             busy_q;
    logic [63:0]      rkey;
    logic [BLK_W-1:0] x;
    logic [BLK_W-1:0] sc;
    logic [BLK_W-1:0] rnd_out;
    logic [3:0]       nib;
    logic [3:0]       sb;

    rectangle128_keymem #(
        .DEPTH(NROUNDS + 1)
    ) u_keymem (
        .Clk       (Clk),
        .RstN      (RstN),
        .flush     (flush),
        .WE        (WE),
        .WAddr     (WAddr),
        .KeyIn     (KeyIn),
        .RAddr     (rnd),
        .RData     (rkey),
        .key_ready (key_ready)
    );

    assign bus.in_ready   = (fsm == S_IDLE) && key_ready;
    assign bus.out_valid  = ov_q;
    assign bus.ciphertext = ct;
    assign busy           = busy_q;

    // Key add then S-box on every 4-bit column.
    always_comb begin
        x   = st ^ rkey;
        sc  = '0;
        nib = '0;
        sb  = '0;
        for (int j = 0; j < ROW_W; j++) begin
            nib = {x[3*ROW_W+j], x[2*ROW_W+j],
                   x[ROW_W+j], x[j]};
            sb  = sbox(nib);
            sc[j]         = sb[0];
            sc[ROW_W+j]   = sb[1];
            sc[2*ROW_W+j] = sb[2];
            sc[3*ROW_W+j] = sb[3];
        end
    end

    // Row rotations: 13, 12, 1, 0 from row3 down.
    assign rnd_out = {sc[50:48], sc[63:51],
                      sc[35:32], sc[47:36],
                      sc[30:16], sc[31],
                      sc[15:0]};

    // Control FSM with registered status outputs.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            fsm    <= S_IDLE;
            rnd    <= '0;
            st     <= '0;
            ct     <= '0;
            ov_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            unique case (fsm)
                S_IDLE: begin
                    if (bus.in_valid && key_ready) begin
                        st     <= bus.plaintext;
                        rnd    <= '0;
                        busy_q <= 1'b1;
                        fsm    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    st  <= rnd_out;
                    rnd <= rnd + 5'd1;
                    if (rnd == 5'(NROUNDS - 1)) begin
                        fsm <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    st     <= st ^ rkey;
                    ct     <= st ^ rkey;
                    busy_q <= 1'b0;
                    ov_q   <= 1'b1;
                    fsm    <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        ov_q <= 1'b0;
                        fsm  <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rectangle128_enc_core.md
RECTANGLE128_ENC_CORE -- requirements
Module: rectangle128_enc_core

Interface
REQ-001 Parameter NROUNDS, default 25: number of full rounds; 26 subkeys, addresses 0..NROUNDS, are used.
REQ-002 Clk  input  1  single clock for all state; all flops are rising-edge.
REQ-003 RstN  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  from key schedule; low clears key_ready.
REQ-005 WE  input  1  subkey write strobe from key schedule.
REQ-006 WAddr  input  5  subkey write address, valid range 0..25.
REQ-007 KeyIn  input  64  subkey data; rows packed {row3,row2,row1,row0}, 16 bits each.
REQ-008 in_valid  input  1  plaintext valid.
REQ-009 in_ready  output  1  core accepts plaintext this cycle.
REQ-010 plaintext  input  64  block; row0=[15:0], row1=[31:16], row2=[47:32], row3=[63:48].
REQ-011 out_valid  output  1  ciphertext valid, held until accepted.
REQ-012 out_ready  input  1  downstream accepts ciphertext.
REQ-013 ciphertext  output  64  result, same row packing as plaintext.
REQ-014 key_ready  output  1  all 26 subkeys present since the last schedule start.
REQ-015 busy  output  1  high in ROUND or FINAL.

Function
REQ-016 The subkey store SHALL hold 26 x 64 bits; WE=1 writes KeyIn to WAddr at the clock edge; writes with WAddr>25 SHALL be ignored.
REQ-017 Writes SHALL be accepted in every FSM state; the round datapath reads the store combinationally, so a read sees the content present in that cycle.
REQ-018 key_ready SHALL set on the edge where WE=1 and WAddr=25, and SHALL clear on a write with WAddr=0 or when flush=0; if both apply on one edge, the clear wins.
REQ-019 FSM states: IDLE, ROUND, FINAL, DONE.
REQ-020 IDLE: in_ready=key_ready; on in_valid&in_ready, capture plaintext into the state register, set rnd=0, go to ROUND.
REQ-021 ROUND: each cycle, state <= ShiftRow(SubColumn(state ^ K[rnd])) and rnd increments; after the cycle with rnd=NROUNDS-1, go to FINAL.
REQ-022 SubColumn: for each column j=0..15, apply the RECTANGLE S-box to the nibble {row3[j],row2[j],row1[j],row0[j]}. S-box for inputs 0..F: 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2. Output bit i goes to row i.
REQ-023 ShiftRow: row0 unchanged; row1 rotate-left 1; row2 rotate-left 12; row3 rotate-left 13; all rotations on 16 bits.
REQ-024 FINAL: state <= state ^ K[25], then go to DONE.
REQ-025 DONE: out_valid=1 and ciphertext=state; on out_ready=1, go to IDLE. out_valid SHALL drop on the following cycle.
REQ-026 Latency: from the accept edge to the first cycle with out_valid=1 is NROUNDS+1 = 26 cycles.
REQ-027 Throughput: at most one block per 27 cycles; in_ready=0 outside IDLE.
REQ-028 ciphertext SHALL hold its value while out_valid=1 and out_ready=0.
REQ-029 If key_ready clears during ROUND or FINAL, the operation SHALL complete using whatever the store holds; the result is not guaranteed to match the golden model.
REQ-030 rnd SHALL be 5 bits and SHALL never exceed NROUNDS.

Reset
REQ-031 RstN=0 SHALL force: FSM=IDLE, rnd=0, state=0, key_ready=0, in_ready=0, out_valid=0, busy=0, ciphertext=0.
REQ-032 Subkey store contents SHALL NOT be reset; only key_ready gates their use.
REQ-033 Reset asserted mid-operation SHALL abort the block with no output.

Structure
REQ-034 The shared package rectangle128_pkg SHALL hold the S-box function, NROUNDS, row width 16, and the FSM state encoding.
REQ-035 The subkey store (REQ-016 to REQ-018) SHALL be the sub-module rectangle128_keymem; the FSM and round datapath SHALL stay in the top module.

Verification
REQ-036 Reset, then write K0..K25 as all-zero: key_ready=1 the cycle after the WAddr=25 write; in_ready=1.
REQ-037 Drive key 0 through the upstream key schedule, then plaintext 0x0000000000000000: out_valid rises exactly 26 cycles after accept, and ciphertext equals the golden model.
REQ-038 Drive key all-ones, then plaintext 0xFFFFFFFFFFFFFFFF with out_ready held 0 for 10 cycles: ciphertext stays stable, matches the golden model, and in_ready=0 throughout.
REQ-039 Drive in_valid=1 before any key load: no accept, in_ready=0; after the WAddr=25 write, the accept occurs on the next edge.
REQ-040 Drive RstN low at round 12: all outputs go to 0 immediately; after release, a new block with reloaded keys gives the correct ciphertext.
REQ-041 A WE to WAddr=0 on the same edge as a WAddr=25 event, and flush=0 pulses: key_ready=0 in both cases.
